// File: rtl/ame_div_pkg.sv
// Shared types and constants for the affine-ME signed fixed-point divider.
package ame_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Saturation constants are built at this width and then cut down to the data width.
    localparam int CONST_BITS = 128;

    function automatic int div_width(input int data_bits, input int frac_bits);
        return data_bits + frac_bits;
    endfunction

    function automatic logic [CONST_BITS-1:0] sat_max(input int data_bits);
        return (CONST_BITS'(1) << (data_bits - 1)) - CONST_BITS'(1);
    endfunction

    function automatic logic [CONST_BITS-1:0] sat_min(input int data_bits);
        return CONST_BITS'(1) << (data_bits - 1);
    endfunction

endpackage

// File: rtl/ame_div_sat.sv
// Applies the quotient sign to the W-bit magnitude and clamps it to the signed output range.
module ame_div_sat
    import ame_div_pkg::*;
#(
    parameter int COMP_DATA_BITS = 64,
    parameter int W              = 80
) (
    input  logic [W-1:0]              mag_i,
    input  logic                      neg_i,
    output logic [COMP_DATA_BITS-1:0] data_o,
    output logic                      sat_o
);

    localparam logic [COMP_DATA_BITS-1:0] MAX_VAL  = COMP_DATA_BITS'(sat_max(COMP_DATA_BITS));
    localparam logic [COMP_DATA_BITS-1:0] MIN_VAL  = COMP_DATA_BITS'(sat_min(COMP_DATA_BITS));
    localparam logic [W-1:0]              HALF_MAG = W'(1) << (COMP_DATA_BITS - 1);

    logic [COMP_DATA_BITS-1:0] mag_lo;

    assign mag_lo = mag_i[COMP_DATA_BITS-1:0];

    // A negative magnitude of exactly 2^(N-1) is MIN itself, so it does not count as a clamp.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        data_o = '0;
        sat_o  = 1'b0;
        if (neg_i) begin
            if (mag_i > HALF_MAG) begin
                data_o = MIN_VAL;
                sat_o  = 1'b1;
            end else begin
                data_o = ~mag_lo + COMP_DATA_BITS'(1);
            end
        end else begin
            if (mag_i >= HALF_MAG) begin
                data_o = MAX_VAL;
                sat_o  = 1'b1;
            end else begin
                data_o = mag_lo;
            end
        end
    end

endmodule

// File: rtl/ame_div_compute.sv
// Restoring signed fixed-point divider: quotient = (num << FRAC_BITS) / den, one bit per clock.
module ame_div_compute
    import ame_div_pkg::*;
#(
    parameter int COMP_DATA_BITS = 64,
    parameter int FRAC_BITS      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      comp_init_i,
    input  logic [COMP_DATA_BITS-1:0] comp_num_i,
    input  logic [COMP_DATA_BITS-1:0] comp_den_i,
    output logic                      comp_busy_o,
    output logic                      comp_done_o,
    output logic [COMP_DATA_BITS-1:0] comp_data_o,
    output logic                      comp_dz_o,
    output logic                      comp_sat_o
);

    localparam int W        = div_width(COMP_DATA_BITS, FRAC_BITS);
    localparam int CNT_BITS = $clog2(W);
    localparam int MSB      = COMP_DATA_BITS - 1;

    localparam logic [CNT_BITS-1:0]       CNT_LAST = CNT_BITS'(W - 1);
    localparam logic [COMP_DATA_BITS-1:0] MAX_VAL  = COMP_DATA_BITS'(sat_max(COMP_DATA_BITS));
    localparam logic [COMP_DATA_BITS-1:0] MIN_VAL  = COMP_DATA_BITS'(sat_min(COMP_DATA_BITS));

    div_state_e                state_q;
    logic [W-1:0]              dividend_q;
    logic [COMP_DATA_BITS-1:0] divisor_q;
    logic [COMP_DATA_BITS-1:0] rem_q;
    logic [CNT_BITS-1:0]       cnt_q;
    logic                      sign_q;
    logic                      dz_sel_q;
    logic                      busy_q;
    logic                      done_q;
    logic [COMP_DATA_BITS-1:0] data_q;
    logic                      dz_q;
    logic                      sat_q;

    logic [COMP_DATA_BITS-1:0] num_mag;
    logic [COMP_DATA_BITS-1:0] den_mag;
    logic                      den_zero;
    logic [COMP_DATA_BITS:0]   rem_shift;
    logic                      rem_ge;
    logic [COMP_DATA_BITS-1:0] rem_d;
    logic [W-1:0]              dividend_d;
    logic [COMP_DATA_BITS-1:0] sat_data;
    logic                      sat_flag;
    logic [COMP_DATA_BITS-1:0] res_data;
    logic                      res_sat;

    // Magnitudes are unsigned, so |MIN| = 2^(N-1) fits without overflow.
    assign num_mag  = comp_num_i[MSB] ? (~comp_num_i + COMP_DATA_BITS'(1)) : comp_num_i;
    assign den_mag  = comp_den_i[MSB] ? (~comp_den_i + COMP_DATA_BITS'(1)) : comp_den_i;
    assign den_zero = (comp_den_i == '0);

    // The remainder stays below the divisor, so N bits hold it between steps; the shifted
    // trial value needs one more.
    assign rem_shift = {rem_q, dividend_q[W-1]};
    assign rem_ge    = (rem_shift >= {1'b0, divisor_q});
    assign rem_d     = rem_ge ? COMP_DATA_BITS'(rem_shift - {1'b0, divisor_q})
                              : COMP_DATA_BITS'(rem_shift);

    // Quotient bits enter the dividend LSB as its MSBs leave, so after W steps the dividend
    // register holds the quotient magnitude.
    assign dividend_d = {dividend_q[W-2:0], rem_ge};

    ame_div_sat #(
        .COMP_DATA_BITS (COMP_DATA_BITS),
        .W              (W)
    ) u_sat (
        .mag_i  (dividend_q),
        .neg_i  (sign_q),
        .data_o (sat_data),
        .sat_o  (sat_flag)
    );

    // On the divide-by-zero path the dividend still holds |num| << FRAC_BITS and the sign is
    // the numerator's, which is all the dz result needs.
    always_comb begin
        res_data = sat_data;
        res_sat  = sat_flag;
        if (dz_sel_q) begin
            res_sat = 1'b0;
            if (dividend_q == '0) begin
                res_data = '0;
            end else begin
                res_data = sign_q ? MIN_VAL : MAX_VAL;
            end
        end
    end

    // NOTE: state and outputs update with non-blocking assignments; the async reset clears
    // every register, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            dz_sel_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
            dz_q       <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            data_q <= '0;
            dz_q   <= 1'b0;
            sat_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (comp_init_i) begin
                        dividend_q <= W'(num_mag) << FRAC_BITS;
                        divisor_q  <= den_mag;
                        sign_q     <= comp_num_i[MSB] ^ comp_den_i[MSB];
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        dz_sel_q   <= den_zero;
                        busy_q     <= 1'b1;
                        state_q    <= den_zero ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem_q      <= rem_d;
                    dividend_q <= dividend_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_BITS'(1);
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    data_q  <= res_data;
                    dz_q    <= dz_sel_q;
                    sat_q   <= res_sat;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign comp_busy_o = busy_q;
    assign comp_done_o = done_q;
    assign comp_data_o = data_q;
    assign comp_dz_o   = dz_q;
    assign comp_sat_o  = sat_q;

endmodule

// File: tb/tb_ame_div_compute.sv
// Self-checking bench for ame_div_compute: randomized operations against a wide-arithmetic model.
module tb_ame_div_compute;

    localparam int CDB  = 64;
    localparam int FRAC = 16;
    localparam int W    = CDB + FRAC;

    localparam logic [63:0]         MAX_V = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0]         MIN_V = 64'h8000_0000_0000_0000;
    localparam logic signed [127:0] MAX_S = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] MIN_S = -128'sh8000_0000_0000_0000;

    logic        clk_i       = 1'b0;
    logic        rst_n_i     = 1'b1;
    logic        comp_init_i = 1'b0;
    logic [63:0] comp_num_i  = '0;
    logic [63:0] comp_den_i  = '0;
    logic        comp_busy_o;
    logic        comp_done_o;
    logic [63:0] comp_data_o;
    logic        comp_dz_o;
    logic        comp_sat_o;

    ame_div_compute #(
        .COMP_DATA_BITS (CDB),
        .FRAC_BITS      (FRAC)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .comp_init_i (comp_init_i),
        .comp_num_i  (comp_num_i),
        .comp_den_i  (comp_den_i),
        .comp_busy_o (comp_busy_o),
        .comp_done_o (comp_done_o),
        .comp_data_o (comp_data_o),
        .comp_dz_o   (comp_dz_o),
        .comp_sat_o  (comp_sat_o)
    );

    always #5 clk_i = ~clk_i;

    int edge_cnt = 0;
    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [63:0] data;
        bit          dz;
        bit          sat;
        int          done_cyc;
        bit          has_lit;
        logic [63:0] lit;
        logic [1:0]  lit_flags;
    } exp_t;

    exp_t exp_q[$];
    int   tests      = 0;
    int   fails      = 0;
    int   done_count = 0;
    int   last_done  = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%h, need 0x%h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Reference: exact wide signed division (truncates toward zero), then clamp.
    function automatic exp_t model(input logic [63:0] n, input logic [63:0] d);
        exp_t e;
        logic signed [127:0] sn;
        logic signed [127:0] sd;
        logic signed [127:0] q;
        sn = {{64{n[63]}}, n};
        sd = {{64{d[63]}}, d};
        e.done_cyc  = 0;
        e.has_lit   = 1'b0;
        e.lit       = '0;
        e.lit_flags = '0;
        if (sd == 0) begin
            e.dz   = 1'b1;
            e.sat  = 1'b0;
            e.data = (sn > 0) ? MAX_V : ((sn < 0) ? MIN_V : 64'd0);
        end else begin
            q    = (sn <<< FRAC) / sd;
            e.dz = 1'b0;
            if (q > MAX_S) begin
                e.data = MAX_V;
                e.sat  = 1'b1;
            end else if (q < MIN_S) begin
                e.data = MIN_V;
                e.sat  = 1'b1;
            end else begin
                e.data = q[63:0];
                e.sat  = 1'b0;
            end
        end
        return e;
    endfunction

    // Pulses init for one edge; the operation is expected only if nothing is in flight then.
    task automatic start(input logic [63:0] n, input logic [63:0] d, input bit has_lit,
                         input logic [63:0] lit, input logic [1:0] lit_flags, input bit align);
        exp_t e;
        bit   acc;
        if (align) @(negedge clk_i);
        comp_init_i = 1'b1;
        comp_num_i  = n;
        comp_den_i  = d;
        @(posedge clk_i);
        #1;
        comp_init_i = 1'b0;
        comp_num_i  = {$urandom, $urandom};
        comp_den_i  = {$urandom, $urandom};
        acc = 1'b1;
        foreach (exp_q[i]) if (exp_q[i].done_cyc >= edge_cnt) acc = 1'b0;
        if (acc) begin
            e           = model(n, d);
            e.done_cyc  = edge_cnt + ((d == '0) ? 1 : W + 1);
            e.has_lit   = has_lit;
            e.lit       = lit;
            e.lit_flags = lit_flags;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout_pending", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return v;
            1:       return 64'($urandom_range(1, 1000));
            2:       return -64'($urandom_range(1, 1000));
            3:       return MIN_V;
            4:       return MAX_V;
            default: return 64'($signed(v) >>> $urandom_range(0, 63));
        endcase
    endfunction

    exp_t mon_e;
    bit   mon_busy;

    always @(negedge clk_i) begin
        mon_busy = (exp_q.size() > 0) && (edge_cnt < exp_q[0].done_cyc);
        check("busy", 64'(comp_busy_o), 64'(mon_busy));
        if (comp_done_o) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(comp_done_o), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_latency", 64'(edge_cnt), 64'(mon_e.done_cyc));
                check("data", comp_data_o, mon_e.data);
                check("dz", 64'(comp_dz_o), 64'(mon_e.dz));
                check("sat", 64'(comp_sat_o), 64'(mon_e.sat));
                if (mon_e.has_lit) begin
                    check("lit_data", comp_data_o, mon_e.lit);
                    check("lit_flags", 64'({comp_dz_o, comp_sat_o}), 64'(mon_e.lit_flags));
                end
                last_done = edge_cnt;
            end
        end else begin
            check("idle_data", comp_data_o, 64'd0);
            check("idle_flags", 64'({comp_dz_o, comp_sat_o}), 64'd0);
            if (exp_q.size() > 0 && edge_cnt >= exp_q[0].done_cyc) begin
                check("missing_done", 64'(comp_done_o), 64'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    logic [63:0] dir_num [9] = '{64'd3, -64'sd7, 64'd7, 64'd5, -64'sd5, 64'd0,
                                 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000,
                                 64'hFFFF_8000_0000_0000};
    logic [63:0] dir_den [9] = '{64'd2, 64'd2, -64'sd3, 64'd0, 64'd0, 64'd0,
                                 64'd1, -64'sd1, 64'd1};
    logic [63:0] dir_lit [9] = '{64'd98304, -64'sd229376, -64'sd152917,
                                 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0,
                                 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                                 64'h8000_0000_0000_0000};
    logic [1:0]  dir_flg [9] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10,
                                 2'b01, 2'b01, 2'b00};

    initial begin
        int n;
        int first_done;
        int dc_before;
        logic [63:0] rn;
        logic [63:0] rd;

        #1 rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_busy", 64'(comp_busy_o), 64'd0);
        check("reset_done", 64'(comp_done_o), 64'd0);
        check("reset_data", comp_data_o, 64'd0);
        check("reset_flags", 64'({comp_dz_o, comp_sat_o}), 64'd0);
        rst_n_i = 1'b1;

        for (int i = 0; i < 9; i++) begin
            start(dir_num[i], dir_den[i], 1'b1, dir_lit[i], dir_flg[i], 1'b1);
            wait_idle(200);
        end

        // Extra init pulses while busy must be dropped.
        dc_before = done_count;
        start(64'd100, 64'd7, 1'b0, '0, '0, 1'b1);
        repeat (10) @(negedge clk_i);
        start(64'd1, 64'd1, 1'b0, '0, '0, 1'b1);
        repeat (30) @(negedge clk_i);
        start(64'd5, 64'd0, 1'b0, '0, '0, 1'b1);
        wait_idle(200);
        check("ignored_single_done", 64'(done_count - dc_before), 64'd1);

        // Init held during the done cycle starts the next operation immediately.
        start(64'd1000, 64'd3, 1'b0, '0, '0, 1'b1);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!comp_done_o && n < 200);
        check("b2b_first_done", 64'(comp_done_o), 64'd1);
        first_done = edge_cnt;
        start(-64'sd1000, 64'd7, 1'b0, '0, '0, 1'b0);
        wait_idle(200);
        check("b2b_spacing", 64'(last_done - first_done), 64'd82);

        // Reset 40 edges into an operation aborts it.
        start(64'd123456789, -64'sd321, 1'b0, '0, '0, 1'b1);
        repeat (40) @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("abort_busy", 64'(comp_busy_o), 64'd0);
        check("abort_done", 64'(comp_done_o), 64'd0);
        check("abort_data", comp_data_o, 64'd0);
        check("abort_flags", 64'({comp_dz_o, comp_sat_o}), 64'd0);
        exp_q.delete();
        dc_before = done_count;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (100) @(negedge clk_i);
        check("abort_no_done", 64'(done_count - dc_before), 64'd0);
        start(64'd3, 64'd2, 1'b1, 64'd98304, 2'b00, 1'b1);
        wait_idle(200);

        for (int k = 0; k < 40; k++) begin
            rn = rand_operand();
            rd = rand_operand();
            if ($urandom_range(0, 9) == 0) rd = '0;
            start(rn, rd, 1'b0, '0, '0, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 60)) @(negedge clk_i);
                start(rand_operand(), rand_operand(), 1'b0, '0, '0, 1'b1);
            end
            wait_idle(200);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end

        repeat (3) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", tests, fails);
        $fatal(1);
    end

endmodule
